mips_alu: RTL and testbench

- 32-bit integer ALU for the MIPS datapath execute stage.
- Takes two operands and a 4-bit control code from the ALU-control decoder.
- Produces a registered result, a zero flag used by branch-equal logic, and auxiliary overflow and illegal-op flags.
- One-cycle registered latency with a simple valid qualifier.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_alu_if.sv | 35 +++
 rtl/mips_alu_addsub.sv | 43 ++++
 rtl/mips_alu.sv | 101 ++++++++++
 tb/tb_mips_alu.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS execute-stage ALU.
//   ALU_WIDTH : default operand/result width
//   CTL_*     : 4-bit operation codes produced by the ALU-control decoder
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

endpackage

// File: rtl/mips_alu_if.sv
// ----------------------------------------------------------------------------
// mips_alu_if
// Operand/result bundle between the execute stage and the ALU.
//   master : drives in_valid, ctl, a, b; receives the registered results
//   slave  : the ALU side
//   in_valid/ctl/a/b          : request for this cycle
//   out/z/ovf/illegal/out_valid : registered response, one cycle later
// ----------------------------------------------------------------------------
interface mips_alu_if
    import mips_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             z;
    logic             ovf;
    logic             illegal;
    logic             out_valid;

    modport master (
        output in_valid, ctl, a, b,
        input  out, z, ovf, illegal, out_valid
    );

    modport slave (
        input  in_valid, ctl, a, b,
        output out, z, ovf, illegal, out_valid
    );

endinterface

// File: rtl/mips_alu_addsub.sv
// ----------------------------------------------------------------------------
// mips_alu_addsub
// Shared combinational adder/subtractor feeding ADD, SUB and SLT.
//   i_a, i_b    : operands
//   i_sub       : 1 = a - b (b inverted, carry-in 1), 0 = a + b
//   o_sum       : result truncated to WIDTH
//   o_carry     : carry out of the MSB
//   o_ovf       : signed overflow of the selected operation
//   o_sltLess   : signed a < b, valid when i_sub = 1
// ----------------------------------------------------------------------------
module mips_alu_addsub
    import mips_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_sltLess
);

    logic [WIDTH-1:0] w_bOperand;
    logic [WIDTH:0]   w_fullSum;

    assign w_bOperand = i_sub ? ~i_b : i_b;
    assign w_fullSum  = {1'b0, i_a} + {1'b0, w_bOperand} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum      = w_fullSum[WIDTH-1:0];
    assign o_carry    = w_fullSum[WIDTH];

    // Using the effective (possibly inverted) b covers both cases: for ADD the
    // operand signs match, for SUB the original signs differ, and the result
    // sign then disagrees with a.
    assign o_ovf = (i_a[WIDTH-1] == w_bOperand[WIDTH-1]) &&
                   (o_sum[WIDTH-1] != i_a[WIDTH-1]);

    // The raw difference sign is wrong whenever a - b overflows; flipping it
    // by the overflow bit recovers the true signed comparison.
    assign o_sltLess = o_sum[WIDTH-1] ^ o_ovf;

endmodule

// File: rtl/mips_alu.sv
// ----------------------------------------------------------------------------
// mips_alu
// 32-bit MIPS execute-stage ALU with one-cycle registered latency.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mips_alu_if slave
//             in_valid, ctl, a, b         -> request
//             out, z, ovf, illegal, out_valid <- registered response
// Results and flags hold while in_valid is low; only out_valid drops.
// ----------------------------------------------------------------------------
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_alu_if.slave  bus
);

    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_unusedCarry;
    logic             w_arithOvf;
    logic             w_sltLess;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic             w_illegal;

    logic [WIDTH-1:0] r_out;
    logic             r_z;
    logic             r_ovf;
    logic             r_illegal;
    logic             r_outValid;

    // SLT reuses the subtractor to get the signed comparison.
    assign w_sub = (bus.ctl == CTL_SUB) || (bus.ctl == CTL_SLT);

    mips_alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a       (bus.a),
        .i_b       (bus.b),
        .i_sub     (w_sub),
        .o_sum     (w_sum),
        .o_carry   (w_unusedCarry),
        .o_ovf     (w_arithOvf),
        .o_sltLess (w_sltLess)
    );

    // Operation select; undefined codes produce a zero result with the
    // illegal flag set and never report overflow.
    always_comb begin
        w_result  = '0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (bus.ctl)
            CTL_AND: w_result = bus.a & bus.b;
            CTL_OR:  w_result = bus.a | bus.b;
            CTL_ADD: begin
                w_result = w_sum;
                w_ovf    = w_arithOvf;
            end
            CTL_SUB: begin
                w_result = w_sum;
                w_ovf    = w_arithOvf;
            end
            CTL_SLT: w_result = {{(WIDTH-1){1'b0}}, w_sltLess};
            CTL_NOR: w_result = ~(bus.a | bus.b);
            CTL_XOR: w_result = bus.a ^ bus.b;
            default: w_illegal = 1'b1;
        endcase
    end

    // Output registers. z comes from the same w_result loaded into r_out so
    // the two can never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_z        <= 1'b1;
            r_ovf      <= 1'b0;
            r_illegal  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out     <= w_result;
                r_z       <= (w_result == '0);
                r_ovf     <= w_ovf;
                r_illegal <= w_illegal;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.z         = r_z;
    assign bus.ovf       = r_ovf;
    assign bus.illegal   = r_illegal;
    assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_mips_alu.sv
// ----------------------------------------------------------------------------
// tb_mips_alu
// Self-checking bench for mips_alu: directed scenarios from the test plan
// plus randomized traffic compared against a plain-arithmetic reference.
// ----------------------------------------------------------------------------
module tb_mips_alu;
    import mips_pkg::*;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic clk;
    logic rst_n;

    int compared;
    int mismatched;

    logic [31:0] expOut;
    logic        expZ;
    logic        expOvf;
    logic        expIll;
    logic        expValid;

    mips_alu_if #(.WIDTH(32)) bus ();

    mips_alu #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU computed with 64-bit signed arithmetic: overflow is simply
    // "the exact result does not fit in 32 signed bits".
    function automatic void refAlu(input logic [3:0] c, input logic [31:0] x,
                                   input logic [31:0] y, output logic [31:0] r,
                                   output logic o, output logic il);
        longint sx;
        longint sy;
        longint s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 32'h0;
        o  = 1'b0;
        il = 1'b0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: begin
                s = sx + sy;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s = sx - sy;
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: r = ~(x | y);
            4'b1101: r = x ^ y;
            default: il = 1'b1;
        endcase
    endfunction

    // Drive one request onto the bus.
    task automatic driveOp(input logic v, input logic [3:0] c,
                           input logic [31:0] x, input logic [31:0] y);
        bus.in_valid = v;
        bus.ctl      = c;
        bus.a        = x;
        bus.b        = y;
    endtask

    // Clock one edge and advance the expected output state from what was
    // presented before the edge; returns #1 after the edge for sampling.
    task automatic applyStimulus();
        logic [31:0] r;
        logic        o;
        logic        il;
        logic        rs;
        logic        v;
        refAlu(bus.ctl, bus.a, bus.b, r, o, il);
        rs = rst_n;
        v  = bus.in_valid;
        @(posedge clk);
        if (!rs) begin
            expOut = 32'h0; expZ = 1'b1; expOvf = 1'b0; expIll = 1'b0; expValid = 1'b0;
        end else if (v) begin
            expOut = r; expZ = (r == 32'h0); expOvf = o; expIll = il; expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        driveOp(1'b1, CTL_ADD, $urandom, $urandom);
        applyStimulus();
        driveOp(1'b1, CTL_OR, $urandom, $urandom);
        applyStimulus();
        compared++;
        if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !== {32'h0, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=0 z=1 ovf=0 ill=0 vld=0",
                     bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid);
        end
        rst_n = 1'b1;
        driveOp(1'b1, CTL_ADD, 32'd2, 32'd2);
        applyStimulus();
        compared++;
        if ({bus.out, bus.z, bus.out_valid} !== {32'd4, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL first_add: got out=%h z=%b vld=%b, want out=4 z=0 vld=1",
                     bus.out, bus.z, bus.out_valid);
        end
    endtask

    // Directed arithmetic, logic and SLT vectors with known results.
    task automatic test_directed();
        vec_t t[13];
        t = '{
            '{CTL_SUB, 32'd4,          32'd2,          32'd2},
            '{CTL_SUB, 32'd15,         32'd126,        32'hFFFFFF91},
            '{CTL_ADD, 32'h7FFFFFFF,   32'd1,          32'h80000000},
            '{CTL_OR,  32'hFFFF1010,   32'h0000FFFF,   32'hFFFFFFFF},
            '{CTL_NOR, 32'hFFFF1010,   32'h0000FFFF,   32'h00000000},
            '{CTL_AND, 32'hFFFF1010,   32'h0000FFFF,   32'h00001010},
            '{CTL_XOR, 32'hFFFF1010,   32'h0000FFFF,   32'hFFFFEFEF},
            '{CTL_SLT, 32'd100000,     32'd10001,      32'd0},
            '{CTL_SLT, 32'hFFFFFFF9,   32'd6,          32'd1},
            '{CTL_SLT, 32'h4A1BA35D,   32'h98782A64,   32'd0},
            '{CTL_SLT, 32'h7D8C01D7,   32'hB24D0744,   32'd0},
            '{CTL_SLT, 32'hA1A538C4,   32'h2C6F2B94,   32'd1},
            '{CTL_SLT, 32'h4270AA12,   32'hA2C98214,   32'd0}
        };
        foreach (t[i]) begin
            driveOp(1'b1, t[i].c, t[i].a, t[i].b);
            applyStimulus();
            compared++;
            if ({bus.out, bus.z, bus.out_valid} !== {t[i].res, (t[i].res == 32'h0), 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL directed[%0d] ctl=%b: got out=%h z=%b vld=%b, want out=%h z=%b vld=1",
                         i, t[i].c, bus.out, bus.z, bus.out_valid, t[i].res, (t[i].res == 32'h0));
            end
            compared++;
            if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !==
                {expOut, expZ, expOvf, expIll, expValid}) begin
                mismatched++;
                $display("[TB] FAIL directed_flags[%0d]: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=%h z=%b ovf=%b ill=%b vld=%b",
                         i, bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid,
                         expOut, expZ, expOvf, expIll, expValid);
            end
        end
    endtask

    task automatic test_illegal_hold();
        driveOp(1'b1, 4'b0011, 32'h12345678, 32'h9ABCDEF0);
        applyStimulus();
        compared++;
        if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !== {32'h0, 4'b1011}) begin
            mismatched++;
            $display("[TB] FAIL illegal_op: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=0 z=1 ovf=0 ill=1 vld=1",
                     bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid);
        end
        driveOp(1'b0, CTL_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF);
        applyStimulus();
        compared++;
        if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !== {32'h0, 4'b1010}) begin
            mismatched++;
            $display("[TB] FAIL invalid_hold: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=0 z=1 ovf=0 ill=1 vld=0",
                     bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid);
        end
    endtask

    task automatic test_midreset();
        driveOp(1'b1, CTL_ADD, 32'd5, 32'd6);
        applyStimulus();
        compared++;
        if ({bus.out, bus.out_valid} !== {32'd11, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_add: got out=%h vld=%b, want out=0000000b vld=1",
                     bus.out, bus.out_valid);
        end
        rst_n = 1'b0;
        driveOp(1'b1, CTL_SUB, 32'h80000000, 32'd1);
        applyStimulus();
        compared++;
        if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !== {32'h0, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=0 z=1 ovf=0 ill=0 vld=0",
                     bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid);
        end
        rst_n = 1'b1;
    endtask

    // Randomized back-to-back traffic with gaps, illegal codes, corner-case
    // operands and occasional reset pulses.
    task automatic test_random();
        logic [3:0]  pool[10];
        logic [31:0] edges[6];
        logic [31:0] x;
        logic [31:0] y;
        pool  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101,
                  4'b0011, 4'b1000, 4'b1111};
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
        for (int n = 0; n < 400; n++) begin
            x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 32'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            rst_n = ($urandom_range(0, 59) != 0);
            driveOp($urandom_range(0, 3) != 0, pool[$urandom_range(0, 9)], x, y);
            applyStimulus();
            compared++;
            if ({bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid} !==
                {expOut, expZ, expOvf, expIll, expValid}) begin
                mismatched++;
                $display("[TB] FAIL random[%0d]: got out=%h z=%b ovf=%b ill=%b vld=%b, want out=%h z=%b ovf=%b ill=%b vld=%b",
                         n, bus.out, bus.z, bus.ovf, bus.illegal, bus.out_valid,
                         expOut, expZ, expOvf, expIll, expValid);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        driveOp(1'b0, CTL_AND, 32'h0, 32'h0);
        test_reset();
        test_directed();
        test_illegal_hold();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
